// File: rtl/bcd_display_mux.sv
// bcd_display_mux: snapshots four BCD digits once per frame and scans them onto a multiplexed 7-segment display
module bcd_display_mux #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Qdata3,
    input  logic [3:0] Qdata2,
    input  logic [3:0] Qdata1,
    input  logic [3:0] Qdata0,
    input  logic       lzb_en,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_MAX   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0] AN_OFF  = {4{AN_ACTIVE_LOW}};
    localparam logic [15:0][6:0] SEG_LUT = {{6{7'h79}}, 7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                            7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    logic [PW-1:0]   p_q, p_d;
    logic [1:0]      idx_q, idx_d;
    logic            armed_q, armed_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic            lzb_q, lzb_d;
    logic            ft_q, ft_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            tick, snap, lit;
    logic [3:0]      blank_vec;

    // Scan sequencing, frame snapshot and registered digit drive for the next cycle
    always_comb begin
        tick      = p_q == P_MAX;
        snap      = tick && idx_q == 2'd3;
        p_d       = tick ? '0 : p_q + 1'b1;
        idx_d     = idx_q + {1'b0, tick};
        armed_d   = armed_q | snap;
        dig_d     = snap ? {Qdata3, Qdata2, Qdata1, Qdata0} : dig_q;
        lzb_d     = snap ? lzb_en : lzb_q;
        ft_d      = snap;
        blank_vec = {4{lzb_q}} & {dig_q[3] == 4'd0,
                                  dig_q[3] == 4'd0 && dig_q[2] == 4'd0,
                                  dig_q[3] == 4'd0 && dig_q[2] == 4'd0 && dig_q[1] == 4'd0,
                                  1'b0};
        lit       = armed_q && p_q >= P_BLANK && !blank_vec[idx_q];
        an_d      = (lit ? 4'b0001 << idx_q : 4'b0000) ^ AN_OFF;
        seg_d     = (lit ? SEG_LUT[dig_q[idx_q]] : 7'h00) ^ SEG_OFF;
    end

    // State registers; reset parks the scan on digit 3 so the first tick starts frame 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            idx_q   <= 2'd3;
            armed_q <= 1'b0;
            dig_q   <= '0;
            lzb_q   <= 1'b0;
            ft_q    <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            p_q     <= p_d;
            idx_q   <= idx_d;
            armed_q <= armed_d;
            dig_q   <= dig_d;
            lzb_q   <= lzb_d;
            ft_q    <= ft_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = ft_q;
endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Downstream consumer of the 4-digit BCD counter chain.
- Takes the four BCD digit values Qdata3..Qdata0 and drives a time-multiplexed, 4-digit common-anode 7-segment display.
- Snapshots all digits once per scan frame so the display never shows a torn count.
- Provides optional leading-zero blanking, an inter-digit ghosting blank and an invalid-BCD indicator.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with anodes forced off; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1: 1 means segment outputs are inverted (lit = 0).
- AN_ACTIVE_LOW, 1: 1 means anode outputs are inverted (selected = 0).

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- Qdata3, input, 4: BCD thousands digit.
- Qdata2, input, 4: BCD hundreds digit.
- Qdata1, input, 4: BCD tens digit.
- Qdata0, input, 4: BCD units digit.
- lzb_en, input, 1: leading-zero blanking enable; sampled together with the snapshot.
- seg, output, 7: segments {g,f,e,d,c,b,a}.
- an, output, 4: digit select; an[i] drives digit i, with digit 0 = units.
- frame_tick, output, 1: one-cycle pulse on the cycle the snapshot is taken.

Behaviour:
- Reset (async, while rst=1):
  - prescaler p=0, idx=3, armed=0, snapshot digits=0, lzb_snap=0.
  - an = all deselected (4'b1111 if AN_ACTIVE_LOW), seg = all unlit (7'b1111111 if SEG_ACTIVE_LOW), frame_tick=0.
- Prescaler:
  - p counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (p == REFRESH_DIV-1).
- On tick:
  - idx advances mod 4 (3 -> 0 wraps).
  - When the new idx is 0: snapshot <= {Qdata3..Qdata0}, lzb_snap <= lzb_en, armed <= 1.
  - frame_tick is a registered output, so the pulse is 1 on the cycle immediately after that edge.
- The first tick after reset therefore starts frame 0 on digit 0. Outputs stay deselected/unlit until then.
- Output stage registered with 1-cycle latency: an/seg in cycle n+1 reflect idx, p and snapshot of cycle n.
- Anodes are deselected when armed=0, when p < BLANK_CYCLES, or when the current digit is blanked. Otherwise only an[idx] is selected.
- seg shows the decoded snapshot digit for idx and is unlit whenever the anodes are deselected.
- Decode, active-high before polarity inversion, {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10..15 show 'E' = 1111001.
- Leading-zero blanking, only when lzb_snap=1. "Zero" means value 0 exactly; values 10..15 are not zero.
  - digit3 is blanked if d3==0.
  - digit2 is blanked if d3==0 and d2==0.
  - digit1 is blanked if d3==0, d2==0 and d1==0.
  - digit0 is never blanked.
- Input changes mid-frame have no effect until the next frame's snapshot. The inputs are synchronous to clk (same clock as the counters), so no synchronizer is needed.
- Reset mid-slot returns immediately to the reset values. The scan restarts with the first tick REFRESH_DIV cycles after rst deasserts.
- At most one an bit is selected in any cycle (one-hot or none).

Test Plan:
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=1, active-low polarities.
- Reset, then release with Qdata=9,6,7,5 and lzb_en=0:
  - outputs stay an=1111, seg=1111111 until the first tick.
  - frame_tick pulses once.
  - Next, one cycle with an=1111, then 3 cycles with an=1110, seg=~1101101 (5).
  - Then digits 1, 2, 3 follow with 7, 6, 9, each preceded by 1 blank cycle.
- Qdata=0,0,4,0 with lzb_en=1:
  - digit0 shows 0, digit1 shows 4.
  - digit2 and digit3 slots keep an=1111 for the full slot.
  - With lzb_en=0, all four digits are lit.
- Qdata0 changes 5 -> 6 during the digit-2 slot: the display keeps showing 5 until the next frame_tick, then shows 6.
- Qdata1=4'hC: the digit-1 slot shows seg=~1111001 ('E'), and that digit is not treated as zero for blanking.
- Assert rst for 1 cycle in the middle of the digit-2 slot:
  - an/seg go to deselected/unlit asynchronously.
  - After release, the first frame_tick occurs exactly 4 cycles later.
- Run 1000 cycles with random Qdata: the assertion holds that an has at most one active bit every cycle, and frame_tick occurs every 16 cycles.
